fp_accumulator: RTL



---
 rtl/fp_accumulator_pkg.sv | 17 +
 rtl/fp_accumulator_fpa.sv | 87 ++++++++
 rtl/fp_accumulator.sv | 80 ++++++++
 3 files changed

// File: rtl/fp_accumulator_pkg.sv
// rtl/fp_accumulator_pkg.sv - shared widths, constants and FSM encoding for fp_accumulator
package fp_accumulator_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Subnormals share the scale of exponent 1 but carry no hidden bit.
  function automatic logic [7:0] eff_exp(input logic [7:0] e);
    return (e == 8'h00) ? 8'h01 : e;
  endfunction

endpackage

// File: rtl/fp_accumulator_fpa.sv
// rtl/fp_accumulator_fpa.sv - combinational single-precision adder, round-to-nearest-even
module fp_accumulator_fpa
  import fp_accumulator_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic [FP_W-1:0] sum_o,
  output logic            overflow_o
);

  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic        big_s, sml_s, res_s, rnd_up;
  logic [7:0]  big_e, sml_e, diff;
  logic [26:0] big_m, sml_m, sml_sh, norm;
  logic [27:0] raw;
  logic [9:0]  exp_n, exp_r;
  logic [24:0] mant_r;

  assign a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'h0);
  assign b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'h0);
  assign a_inf = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'h0);
  assign b_inf = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'h0);
  assign swap  = b_i[30:0] > a_i[30:0];

  always_comb begin
    big_s  = swap ? b_i[31] : a_i[31];
    sml_s  = swap ? a_i[31] : b_i[31];
    big_e  = swap ? b_i[30:23] : a_i[30:23];
    sml_e  = swap ? a_i[30:23] : b_i[30:23];
    big_m  = {big_e != 8'h00, swap ? b_i[22:0] : a_i[22:0], 3'b000};
    sml_m  = {sml_e != 8'h00, swap ? a_i[22:0] : b_i[22:0], 3'b000};
    diff   = eff_exp(big_e) - eff_exp(sml_e);
    sml_sh = '0;
    norm   = '0;
    sum_o  = FP_ZERO;
    overflow_o = 1'b0;

    // Three extra low bits act as guard, round and sticky.
    if (diff >= 8'd27) begin
      sml_sh = {26'b0, |sml_m};
    end else begin
      sml_sh    = sml_m >> diff;
      sml_sh[0] = sml_sh[0] | (|(sml_m & ~(27'h7FFFFFF << diff)));
    end

    if (big_s == sml_s) raw = {1'b0, big_m} + {1'b0, sml_sh};
    else                raw = {1'b0, big_m} - {1'b0, sml_sh};

    exp_n = {2'b00, eff_exp(big_e)};
    if (raw[27]) begin
      norm  = raw[27:1] | {26'b0, raw[0]};
      exp_n = exp_n + 10'd1;
    end else begin
      norm = raw[26:0];
      for (int i = 0; i < 26; i++) begin
        if (!norm[26] && (exp_n > 10'd1)) begin
          norm  = norm << 1;
          exp_n = exp_n - 10'd1;
        end
      end
    end

    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[26:3]} + {24'b0, rnd_up};
    exp_r  = exp_n;
    if (mant_r[24]) begin
      mant_r = mant_r >> 1;
      exp_r  = exp_r + 10'd1;
    end

    res_s = (raw == 28'h0) ? (big_s & sml_s) : big_s;

    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31]))) begin
      sum_o = 32'h7FC00000;
    end else if (a_inf) begin
      sum_o = a_i;
    end else if (b_inf) begin
      sum_o = b_i;
    end else if (exp_r >= 10'd255) begin
      sum_o      = {res_s, 8'hFF, 23'h0};
      overflow_o = 1'b1;
    end else begin
      sum_o = {res_s, mant_r[23] ? exp_r[7:0] : 8'h00, mant_r[22:0]};
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// rtl/fp_accumulator.sv - streaming float accumulator: sums a stream, holds result until taken
module fp_accumulator
  import fp_accumulator_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  state_e           state_q, state_d;
  logic [FP_W-1:0]  acc_q, acc_d, fpa_sum;
  logic             ovf_q, ovf_d, fpa_ovf;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fp_accumulator_fpa u_fpa (
    .a_i       (acc_q),
    .b_i       (in_data),
    .sum_o     (fpa_sum),
    .overflow_o(fpa_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= FP_ZERO;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          acc_d = fpa_sum;
          ovf_d = ovf_q | fpa_ovf;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = FP_ZERO;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
  assign out_count    = cnt_q;

endmodule
